riscv_ctrl_seq: RTL and testbench
=================================

Name: riscv_ctrl_seq

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the program counter's update enable (pcEn) and source select (pcSrc) exactly once per retired instruction.
- Handshakes with the shared instruction/data memory port, and halts or faults on SYSTEM or illegal opcodes and on memory timeout.

Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles for memReady in FETCH/MEM before FAULT (1..2^TO_W-1).
- TO_W, 4, width of the timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- run  in  1  start/continue execution; sampled at instruction boundaries.
- opcode  in  7  instr[6:0] from the instruction register, valid from DECODE onward.
- branchTaken  in  1  branch comparison result, valid in EXEC.
- memReady  in  1  memory acknowledge for the current memReq.
- memReq  out  1  memory access request.
- memWe  out  1  write strobe, qualifies memReq.
- irWrite  out  1  load the instruction register.
- regWe  out  1  register-file write enable.
- pcEn  out  1  program counter update enable.
- pcSrc  out  1  0: PC+1 word; 1: PC+offset.
- state  out  3  current state code.
- halted  out  1  HALT reached.
- fault  out  1  FAULT reached.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- rstN low, at any time including mid-instruction: state=IDLE and timeout counter=0 immediately. All outputs 0 while in reset.
- Outputs are decoded combinationally from state, the latched opcode class and memReady. Every output not listed for a state is 0.
- IDLE:
  - run=1 -> FETCH next cycle; else stay.
- FETCH:
  - memReq=1, memWe=0.
  - On the cycle memReady=1: irWrite=1, counter cleared, -> DECODE.
  - Otherwise counter+1; the cycle the counter reaches MEM_TIMEOUT with memReady=0 -> FAULT.
- DECODE (1 cycle): latch the opcode class.
  - LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111 -> EXEC.
  - SYSTEM 1110011 -> HALT.
  - Any other value -> FAULT.
- EXEC (1 cycle):
  - BRANCH: pcEn=1, pcSrc=branchTaken; instruction retires -> boundary.
  - LOAD/STORE -> MEM.
  - All others -> WB.
- MEM: memReq=1, memWe=1 for STORE, 0 for LOAD. Timeout rule as FETCH.
  - LOAD on memReady -> WB.
  - STORE on memReady: pcEn=1, pcSrc=0; retires -> boundary.
- WB (1 cycle): regWe=1, pcEn=1.
  - pcSrc=1 for JAL/JALR, 0 otherwise; retires -> boundary.
- Boundary: next state is FETCH if run=1, else IDLE. Deasserting run never aborts an instruction in flight.
- HALT: halted=1. FAULT: fault=1. Both are sticky until rstN; run is ignored.
- Invariants:
  - pcEn is high for exactly one cycle per retired instruction and never outside EXEC/MEM/WB.
  - memReq drops the cycle after memReady is seen.
  - The counter clears on every state entry.
- Latency (memReady same cycle as request): ALU/jump 4 cycles, branch 3, store 4, load 5.
- memReady high while memReq=0 is ignored.

Test Plan:
- Reset then run=1, opcode=0010011, memReady tied 1 -> states 1,2,3,5 repeating; pcEn=1, pcSrc=0, regWe=1 only in state 5; one pcEn every 4 cycles.
- BRANCH 1100011 with branchTaken=1, then again with branchTaken=0 -> pcEn=1 in EXEC both times, pcSrc=1 then 0, regWe never asserted, 3 cycles each.
- LOAD with memReady delayed 3 cycles in both FETCH and MEM -> memReq held high 4 cycles in each, irWrite a single pulse, regWe+pcEn in WB; total 11 cycles. STORE: memWe=1 only in MEM, pcEn on its memReady cycle.
- memReady held 0 in FETCH -> FAULT entered after 15 wait cycles, fault=1; run toggling changes nothing until rstN pulse -> state=0.
- opcode=1110011 -> HALT after DECODE, halted=1, no pcEn. opcode=1111111 -> FAULT.
- run dropped mid-LOAD, rstN asserted asynchronously mid-MEM (off clock edge):
  - run drop: the load completes (pcEn pulse), then IDLE.
  - reset: state=0 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_ctrl_seq.sv
// riscv_ctrl_seq -- multi-cycle control sequencer for the RV32I core.
//
// Moves each instruction through FETCH, DECODE, EXEC, MEM and WB. It pulses
// pcEn exactly once per retired instruction. It handshakes with the shared
// instruction/data memory port and stops in HALT (SYSTEM opcode) or FAULT
// (illegal opcode or memory timeout) until reset.
//
// Ports:
//   clk, rstN    clock (rising edge), asynchronous active-low reset
//   run          start/continue; sampled only at instruction boundaries
//   opcode       instr[6:0] from the IR, valid from DECODE onward
//   branchTaken  branch comparison result, valid in EXEC
//   memReady     memory acknowledge for the current memReq
//   memReq/memWe memory request and write strobe
//   irWrite      load the instruction register
//   regWe        register-file write enable
//   pcEn/pcSrc   PC update enable; source 0 = PC+1 word, 1 = PC+offset
//   state        current state code
//   halted/fault sticky terminal-state flags
module riscv_ctrl_seq #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       branchTaken,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWe,
  output logic       irWrite,
  output logic       regWe,
  output logic       pcEn,
  output logic       pcSrc,
  output logic [2:0] state,
  output logic       halted,
  output logic       fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  // Opcode classes: only the distinctions later states care about are kept.
  localparam logic [2:0] C_ALU    = 3'd0;  // OP, OP-IMM, LUI, AUIPC
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_STORE  = 3'd2;
  localparam logic [2:0] C_BRANCH = 3'd3;
  localparam logic [2:0] C_JUMP   = 3'd4;  // JAL, JALR (PC+offset in WB)

  logic [2:0]      nxt;
  logic [2:0]      cls;
  logic [2:0]      dec_cls;
  logic            dec_ok;
  logic            dec_sys;
  logic [TO_W-1:0] cnt;
  logic            timeout;
  logic [2:0]      bnd;

  // The counter is compared one short of the limit. FAULT is therefore
  // taken on the MEM_TIMEOUT-th consecutive wait cycle.
  assign timeout = (cnt == TO_W'(MEM_TIMEOUT - 1)) && !memReady;
  assign bnd     = run ? S_FETCH : S_IDLE;

  always_comb begin
    dec_cls = C_ALU;
    dec_ok  = 1'b1;
    dec_sys = 1'b0;
    case (opcode)
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111,
      7'b1100111: dec_cls = C_JUMP;
      7'b0110011,
      7'b0010011,
      7'b0110111,
      7'b0010111: dec_cls = C_ALU;
      7'b1110011: dec_sys = 1'b1;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    nxt     = state;
    memReq  = 1'b0;
    memWe   = 1'b0;
    irWrite = 1'b0;
    regWe   = 1'b0;
    pcEn    = 1'b0;
    pcSrc   = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;
    case (state)
      S_IDLE: if (run) nxt = S_FETCH;
      S_FETCH: begin
        memReq = 1'b1;
        if (memReady) begin
          irWrite = 1'b1;
          nxt     = S_DECODE;
        end else if (timeout) begin
          nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        if (dec_sys)     nxt = S_HALT;
        else if (dec_ok) nxt = S_EXEC;
        else             nxt = S_FAULT;
      end
      S_EXEC: begin
        case (cls)
          C_BRANCH: begin
            pcEn  = 1'b1;
            pcSrc = branchTaken;
            nxt   = bnd;
          end
          C_LOAD, C_STORE: nxt = S_MEM;
          default:         nxt = S_WB;
        endcase
      end
      S_MEM: begin
        memReq = 1'b1;
        memWe  = (cls == C_STORE);
        if (memReady) begin
          if (cls == C_STORE) begin
            pcEn = 1'b1;
            nxt  = bnd;
          end else begin
            nxt = S_WB;
          end
        end else if (timeout) begin
          nxt = S_FAULT;
        end
      end
      S_WB: begin
        regWe = 1'b1;
        pcEn  = 1'b1;
        pcSrc = (cls == C_JUMP);
        nxt   = bnd;
      end
      S_HALT:  halted = 1'b1;
      default: fault  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= S_IDLE;
      cls   <= C_ALU;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) cls <= dec_cls;
      // Clear on every state change; count only while waiting on memory.
      if (nxt != state)
        cnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_ctrl_seq.sv
// Directed bench for riscv_ctrl_seq. Each step drives the inputs and pushes
// the expected {state, outputs} for that cycle. It then pops and compares
// at the falling edge.
module tb_riscv_ctrl_seq;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       run = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       branchTaken = 1'b0;
  logic       memReady = 1'b0;
  logic       memReq, memWe, irWrite, regWe, pcEn, pcSrc, halted, fault;
  logic [2:0] state;

  int n_chk = 0;
  int n_fail = 0;
  logic [10:0] sb[$];

  localparam logic [6:0] OP_ALU = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Output bit masks: {memReq, memWe, irWrite, regWe, pcEn, pcSrc, halted, fault}
  localparam logic [7:0] M = 8'h80, W = 8'h40, I = 8'h20, R = 8'h10;
  localparam logic [7:0] P = 8'h08, S = 8'h04, H = 8'h02, F = 8'h01;

  riscv_ctrl_seq #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .rstN(rstN), .run(run), .opcode(opcode),
    .branchTaken(branchTaken), .memReady(memReady), .memReq(memReq),
    .memWe(memWe), .irWrite(irWrite), .regWe(regWe), .pcEn(pcEn),
    .pcSrc(pcSrc), .state(state), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] observed();
    return {state, memReq, memWe, irWrite, regWe, pcEn, pcSrc, halted, fault};
  endfunction

  // One clock cycle: drive, expect, sample at negedge, advance past posedge.
  task automatic cyc(input string tag, input logic r, input logic [6:0] op,
                     input logic br, input logic rdy,
                     input logic [2:0] st, input logic [7:0] o);
    logic [10:0] e, g;
    run = r; opcode = op; branchTaken = br; memReady = rdy;
    sb.push_back({st, o});
    @(negedge clk);
    e = sb.pop_front();
    g = observed();
    n_chk++;
    assert (g === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, g, e);
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    logic [10:0] g;
    rstN = 1'b0;
    #1;
    g = observed();
    n_chk++;
    assert (g === 11'd0) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, g, 11'd0);
    end
    run = 1'b0; memReady = 1'b0;
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    do_reset("reset_init");

    // ALU op with memory always ready: 1,2,3,5 repeating.
    cyc("alu_idle", 1, OP_ALU, 0, 1, 3'd0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      cyc("alu_fetch", 1, OP_ALU, 0, 1, 3'd1, M | I);
      cyc("alu_dec",   1, OP_ALU, 0, 1, 3'd2, 8'h00);
      cyc("alu_exec",  1, OP_ALU, 0, 1, 3'd3, 8'h00);
      cyc("alu_wb",    1, OP_ALU, 0, 1, 3'd5, R | P);
    end
    cyc("alu_fetch3", 1, OP_ALU, 0, 1, 3'd1, M | I);
    do_reset("reset_alu");

    // Branch taken, then not taken.
    cyc("br_idle",   1, OP_BR, 1, 1, 3'd0, 8'h00);
    cyc("br_fetch",  1, OP_BR, 1, 1, 3'd1, M | I);
    cyc("br_dec",    1, OP_BR, 1, 1, 3'd2, 8'h00);
    cyc("br_exec_t", 1, OP_BR, 1, 1, 3'd3, P | S);
    cyc("br_fetch2", 1, OP_BR, 0, 1, 3'd1, M | I);
    cyc("br_dec2",   1, OP_BR, 0, 1, 3'd2, 8'h00);
    cyc("br_exec_n", 0, OP_BR, 0, 1, 3'd3, P);
    cyc("br_idle2",  0, OP_BR, 0, 1, 3'd0, 8'h00);

    // JAL selects PC+offset in WB.
    cyc("jal_idle",  1, OP_JAL, 0, 1, 3'd0, 8'h00);
    cyc("jal_fetch", 1, OP_JAL, 0, 1, 3'd1, M | I);
    cyc("jal_dec",   1, OP_JAL, 0, 1, 3'd2, 8'h00);
    cyc("jal_exec",  1, OP_JAL, 0, 1, 3'd3, 8'h00);
    cyc("jal_wb",    0, OP_JAL, 0, 1, 3'd5, R | P | S);
    cyc("jal_idle2", 0, OP_JAL, 0, 1, 3'd0, 8'h00);

    // Load with 3-cycle memory delay in FETCH and MEM, run dropped mid-load.
    cyc("ld_idle", 1, OP_LD, 0, 0, 3'd0, 8'h00);
    for (int k = 0; k < 3; k++) cyc("ld_fetch_wait", 1, OP_LD, 0, 0, 3'd1, M);
    cyc("ld_fetch_rdy", 1, OP_LD, 0, 1, 3'd1, M | I);
    cyc("ld_dec",       1, OP_LD, 0, 1, 3'd2, 8'h00);
    cyc("ld_exec",      1, OP_LD, 0, 1, 3'd3, 8'h00);
    for (int k = 0; k < 3; k++) cyc("ld_mem_wait", 0, OP_LD, 0, 0, 3'd4, M);
    cyc("ld_mem_rdy", 0, OP_LD, 0, 1, 3'd4, M);
    cyc("ld_wb",      0, OP_LD, 0, 1, 3'd5, R | P);
    cyc("ld_idle2",   0, OP_LD, 0, 1, 3'd0, 8'h00);

    // Store: memWe only in MEM, retires on its memReady cycle.
    cyc("st_idle",   1, OP_ST, 0, 1, 3'd0, 8'h00);
    cyc("st_fetch",  1, OP_ST, 0, 1, 3'd1, M | I);
    cyc("st_dec",    1, OP_ST, 0, 1, 3'd2, 8'h00);
    cyc("st_exec",   1, OP_ST, 0, 1, 3'd3, 8'h00);
    cyc("st_mem",    1, OP_ST, 0, 1, 3'd4, M | W | P);
    cyc("st_fetch2", 1, OP_ST, 0, 1, 3'd1, M | I);
    do_reset("reset_store");

    // 14 wait cycles is still within budget.
    cyc("to14_idle", 1, OP_ALU, 0, 0, 3'd0, 8'h00);
    for (int k = 0; k < 14; k++) cyc("to14_wait", 1, OP_ALU, 0, 0, 3'd1, M);
    cyc("to14_rdy", 1, OP_ALU, 0, 1, 3'd1, M | I);
    cyc("to14_dec", 1, OP_ALU, 0, 1, 3'd2, 8'h00);
    do_reset("reset_to14");

    // 15 wait cycles in FETCH -> FAULT, sticky against run.
    cyc("to_idle", 1, OP_ALU, 0, 0, 3'd0, 8'h00);
    for (int k = 0; k < 15; k++) cyc("to_wait", 1, OP_ALU, 0, 0, 3'd1, M);
    cyc("to_fault",  1, OP_ALU, 0, 1, 3'd7, F);
    cyc("to_fault2", 0, OP_ALU, 0, 1, 3'd7, F);
    cyc("to_fault3", 1, OP_ALU, 0, 1, 3'd7, F);
    do_reset("reset_fault");

    // SYSTEM -> HALT, sticky.
    cyc("sys_idle",  1, OP_SYS, 0, 1, 3'd0, 8'h00);
    cyc("sys_fetch", 1, OP_SYS, 0, 1, 3'd1, M | I);
    cyc("sys_dec",   1, OP_SYS, 0, 1, 3'd2, 8'h00);
    cyc("sys_halt",  0, OP_SYS, 0, 1, 3'd6, H);
    cyc("sys_halt2", 1, OP_SYS, 0, 1, 3'd6, H);
    do_reset("reset_halt");

    // Illegal opcode -> FAULT.
    cyc("bad_idle",  1, OP_BAD, 0, 1, 3'd0, 8'h00);
    cyc("bad_fetch", 1, OP_BAD, 0, 1, 3'd1, M | I);
    cyc("bad_dec",   1, OP_BAD, 0, 1, 3'd2, 8'h00);
    cyc("bad_fault", 1, OP_BAD, 0, 1, 3'd7, F);
    do_reset("reset_bad");

    // Asynchronous reset in the middle of a load's MEM wait.
    cyc("ar_idle",  1, OP_LD, 0, 1, 3'd0, 8'h00);
    cyc("ar_fetch", 1, OP_LD, 0, 1, 3'd1, M | I);
    cyc("ar_dec",   1, OP_LD, 0, 1, 3'd2, 8'h00);
    cyc("ar_exec",  1, OP_LD, 0, 0, 3'd3, 8'h00);
    cyc("ar_mem",   1, OP_LD, 0, 0, 3'd4, M);
    memReady = 1'b0;
    do_reset("async_reset_mem");
    cyc("ar_after", 0, OP_LD, 0, 1, 3'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
